// File: rtl/note_tile_drawer.sv
// rtl/note_tile_drawer.sv - erase/redraw of one lane's falling note tile into the VGA frame-buffer write port
// Optional feature macro: TILE_OUTLINE_EN (draw the tile border in OUTLINE_COLOUR).
module note_tile_drawer #(
    parameter int                  X_POS          = 100,
    parameter int                  TILE_W         = 8,
    parameter int                  TILE_H         = 4,
    parameter int                  Y_MAX          = 240,
    parameter int                  COLOUR_W       = 3,
    parameter logic [COLOUR_W-1:0] TILE_COLOUR    = 3'b110,
    parameter logic [COLOUR_W-1:0] BG_COLOUR      = 3'b000,
    parameter logic [COLOUR_W-1:0] OUTLINE_COLOUR = 3'b111
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                data_en_i,
    input  logic [7:0]          data_i,
    output logic [8:0]          x_o,
    output logic [7:0]          y_o,
    output logic [COLOUR_W-1:0] colour_o,
    output logic                plot_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

    localparam logic [4:0] DX_LAST = 5'(TILE_W - 1);
    localparam logic [4:0] DY_LAST = 5'(TILE_H - 1);
    localparam logic [8:0] X_BASE  = 9'(X_POS);
    localparam logic [8:0] Y_LIMIT = 9'(Y_MAX);
`ifdef TILE_OUTLINE_EN
    localparam bit OUTLINE_EN = 1'b1;
`else
    localparam bit OUTLINE_EN = 1'b0;
`endif

    state_t                state_q;
    logic [4:0]            dx_q, dy_q;
    logic [7:0]            old_y_q, new_y_q, req_y_q, shown_y_q;
    logic                  shown_valid_q;
    logic [8:0]            x_q;
    logic [7:0]            y_q;
    logic [COLOUR_W-1:0]   colour_q;
    logic                  plot_q, busy_q, done_q;

    logic [7:0]            base_y;
    logic [8:0]            y_d;
    logic [8:0]            x_d;
    logic [COLOUR_W-1:0]   colour_d;
    logic                  plot_d;
    logic                  on_border, last_x, last_pix;

    // Pixel for the current scan position; y is kept 9 bits wide so rows past the bottom clip rather than wrap.
    always_comb begin
        base_y    = (state_q == S_ERASE) ? old_y_q : new_y_q;
        y_d       = {1'b0, base_y} + {4'b0, dy_q};
        x_d       = X_BASE + {4'b0, dx_q};
        on_border = (dx_q == 5'd0) || (dx_q == DX_LAST) || (dy_q == 5'd0) || (dy_q == DY_LAST);
        last_x    = (dx_q == DX_LAST);
        last_pix  = last_x && (dy_q == DY_LAST);
        plot_d    = (y_d < Y_LIMIT);
        if (state_q == S_ERASE) begin
            colour_d = BG_COLOUR;
        end else if (OUTLINE_EN && on_border) begin
            colour_d = OUTLINE_COLOUR;
        end else begin
            colour_d = TILE_COLOUR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            dx_q          <= 5'd0;
            dy_q          <= 5'd0;
            old_y_q       <= 8'd0;
            new_y_q       <= 8'd0;
            req_y_q       <= 8'd0;
            shown_y_q     <= 8'd0;
            shown_valid_q <= 1'b0;
            x_q           <= 9'd0;
            y_q           <= 8'd0;
            colour_q      <= BG_COLOUR;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            if (data_en_i) begin
                req_y_q <= data_i;
            end
            plot_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (data_en_i && (!shown_valid_q || data_i != shown_y_q)) begin
                        old_y_q <= shown_y_q;
                        new_y_q <= data_i;
                        dx_q    <= 5'd0;
                        dy_q    <= 5'd0;
                        state_q <= shown_valid_q ? S_ERASE : S_DRAW;
                    end
                end
                S_ERASE, S_DRAW: begin
                    x_q      <= x_d;
                    y_q      <= y_d[7:0];
                    colour_q <= colour_d;
                    plot_q   <= plot_d;
                    busy_q   <= 1'b1;
                    if (last_pix) begin
                        dx_q <= 5'd0;
                        dy_q <= 5'd0;
                        if (state_q == S_ERASE) begin
                            state_q <= S_DRAW;
                        end else begin
                            shown_y_q     <= new_y_q;
                            shown_valid_q <= 1'b1;
                            state_q       <= S_DONE;
                        end
                    end else if (last_x) begin
                        dx_q <= 5'd0;
                        dy_q <= dy_q + 5'd1;
                    end else begin
                        dx_q <= dx_q + 5'd1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    // Only the newest request survives; anything that arrived mid-redraw is dropped.
                    if (req_y_q != shown_y_q) begin
                        old_y_q <= shown_y_q;
                        new_y_q <= req_y_q;
                        dx_q    <= 5'd0;
                        dy_q    <= 5'd0;
                        state_q <= S_ERASE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign colour_o = colour_q;
    assign plot_o   = plot_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_note_tile_drawer.sv
// tb/tb_note_tile_drawer.sv - randomized self-checking bench for note_tile_drawer
module tb_note_tile_drawer;

    localparam int         X_POS  = 100;
    localparam int         TILE_W = 8;
    localparam int         TILE_H = 4;
    localparam int         Y_MAX  = 240;
    localparam logic [2:0] TILE_C = 3'b110;
    localparam logic [2:0] BG_C   = 3'b000;
    localparam logic [2:0] OUT_C  = 3'b111;
    localparam int         TILE_PIX = TILE_W * TILE_H;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       data_en_i = 1'b0;
    logic [7:0] data_i = 8'd0;
    logic [8:0] x_o;
    logic [7:0] y_o;
    logic [2:0] colour_o;
    logic       plot_o, busy_o, done_o;

    int n_vec = 0;
    int n_bad = 0;
    int obs_q[$];
    int exp_q[$];
    int busy_tot = 0;
    int done_tot = 0;
    int shown = -1;

    always #5 clk = ~clk;

    note_tile_drawer dut (
        .clk      (clk),
        .resetn   (resetn),
        .data_en_i(data_en_i),
        .data_i   (data_i),
        .x_o      (x_o),
        .y_o      (y_o),
        .colour_o (colour_o),
        .plot_o   (plot_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    function automatic int pack(input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc);
        return {12'b0, px, py, pc};
    endfunction

    always @(negedge clk) begin
        if (plot_o) obs_q.push_back(pack(x_o, y_o, colour_o));
        if (busy_o) busy_tot++;
        if (done_o) done_tot++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every pixel of a tile in scan order, rows at or below Y_MAX suppressed.
    task automatic add_tile(input int ty, input bit draw);
        logic [2:0] c;
        for (int dy = 0; dy < TILE_H; dy++) begin
            for (int dx = 0; dx < TILE_W; dx++) begin
                c = draw ? TILE_C : BG_C;
`ifdef TILE_OUTLINE_EN
                if (draw && (dx == 0 || dx == TILE_W - 1 || dy == 0 || dy == TILE_H - 1)) c = OUT_C;
`endif
                if (ty + dy < Y_MAX) exp_q.push_back(pack(9'(X_POS + dx), 8'(ty + dy), c));
            end
        end
    endtask

    task automatic compare_pixels(input int start);
        check("pix_count", obs_q.size() - start, exp_q.size());
        for (int i = 0; i < exp_q.size() && start + i < obs_q.size(); i++)
            check("pixel", obs_q[start + i], exp_q[i]);
    endtask

    function automatic logic [7:0] pick(input int avoid);
        logic [7:0] v;
        do begin
            if ($urandom_range(0, 3) == 0) v = 8'($urandom_range(0, 255));
            else v = 8'(180 + 4 * $urandom_range(0, 4));
        end while (int'(v) == avoid);
        return v;
    endfunction

    task automatic do_move(input logic [7:0] v);
        int s_obs, s_busy, s_done, n, blen;
        s_obs  = obs_q.size();
        s_busy = busy_tot;
        s_done = done_tot;
        exp_q.delete();
        if (shown >= 0) add_tile(shown, 1'b0);
        add_tile(int'(v), 1'b1);
        blen = (shown >= 0) ? 2 * TILE_PIX : TILE_PIX;
        data_i    = v;
        data_en_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy_o && n < 10);
        check("start_latency", n, 2);
        n = 0;
        while (!done_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("busy_to_done", n, blen);
        repeat (2) @(negedge clk);
        compare_pixels(s_obs);
        check("busy_cycles", busy_tot - s_busy, blen);
        check("done_pulses", done_tot - s_done, 1);
        shown = int'(v);
    endtask

    task automatic do_coalesce(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int s_obs, s_busy, s_done, n;
        s_obs  = obs_q.size();
        s_busy = busy_tot;
        s_done = done_tot;
        exp_q.delete();
        add_tile(shown, 1'b0);
        add_tile(int'(a), 1'b1);
        add_tile(int'(a), 1'b0);
        add_tile(int'(c), 1'b1);
        data_i    = a;
        data_en_i = 1'b1;
        repeat (6) @(negedge clk);
        data_i = b;
        repeat (4) @(negedge clk);
        data_i = c;
        n = 0;
        while (done_tot - s_done < 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        compare_pixels(s_obs);
        check("coalesce_busy", busy_tot - s_busy, 4 * TILE_PIX);
        check("coalesce_done", done_tot - s_done, 2);
        shown = int'(c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, int'(x_o), 0);
        check({tag, "_y"}, int'(y_o), 0);
        check({tag, "_colour"}, int'(colour_o), int'(BG_C));
        check({tag, "_plot"}, int'(plot_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
    endtask

    initial begin
        int s_busy, target, n;
        logic [7:0] a, b, c;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        do_move(8'd180);
        do_move(8'd184);
        do_coalesce(8'd188, 8'd192, 8'd196);
        do_move(8'd180);
        do_move(8'd238);

        // With data_en low, a differing position must not trigger a redraw.
        s_busy    = busy_tot;
        data_en_i = 1'b0;
        data_i    = 8'd192;
        repeat (10) @(negedge clk);
        check("no_enable_idle", busy_tot - s_busy, 0);
        data_i    = 8'(shown);
        data_en_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_move(pick(shown));
        for (int i = 0; i < 3; i++) begin
            a = pick(shown);
            b = pick(-1);
            c = pick(int'(a));
            do_coalesce(a, b, c);
        end

        // Reset while drawing: outputs must clear without waiting for a clock edge.
        a = pick(shown);
        data_i    = a;
        data_en_i = 1'b1;
        target    = obs_q.size() + TILE_PIX + 10;
        n = 0;
        while (obs_q.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_pixel10", int'(obs_q.size() >= target), 1);
        #1;
        resetn    = 1'b0;
        data_en_i = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        shown  = -1;
        @(negedge clk);
        do_move(8'd180);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
